pipe_issue_ctrl: RTL



---
 rtl/pipe_issue_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: buffers instructions in a small FIFO and issues one per
// cycle, inserting bubbles while the head reads a register an in-flight producer still owes.
module pipe_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        out_valid,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int SB = LAT - 1;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    instr_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [SB-1:0]   sb_v;
    logic [3:0]      sb_rd [SB];

    instr_t head;
    logic   not_empty;
    logic   hazard;
    logic   issue;
    logic   push;

    // Hazard compares only the head against producers whose result is not yet written back.
    always_comb begin
        head      = mem[rd_ptr];
        not_empty = (count != '0);
        hazard    = 1'b0;
        for (int k = 0; k < SB; k++) begin
            if (sb_v[k] && ((sb_rd[k] == head.rs1) || (sb_rd[k] == head.rs2))) begin
                hazard = not_empty;
            end
        end
        issue    = not_empty && !hazard;
        in_ready = (count < (PW + 1)'(DEPTH)) && !rst;
        push     = in_valid && in_ready;
        busy     = not_empty || (|sb_v);
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sb_v      <= '0;
            for (int k = 0; k < SB; k++) begin
                sb_rd[k] <= '0;
            end
            out_valid <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            func      <= '0;
            addr      <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            // The oldest entry falls off once its result has reached the register bank.
            for (int k = SB - 1; k > 0; k--) begin
                sb_v[k]  <= sb_v[k-1];
                sb_rd[k] <= sb_rd[k-1];
            end
            sb_v[0]  <= issue;
            sb_rd[0] <= head.rd;

            out_valid <= issue;
            if (issue) begin
                rs1  <= head.rs1;
                rs2  <= head.rs2;
                rd   <= head.rd;
                func <= head.func;
                addr <= head.addr;
            end

            if (hazard && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule
